// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Wide enough to hold WIDTH itself, so the step counter loads without wrapping.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then the
// arithmetic right shift of {A, Q, q_m1}.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] operand;
  logic [WIDTH:0] sum;
  logic           do_add;
  logic           do_sub;

  assign do_sub = q_i[0] & ~qm1_i;
  assign do_add = ~q_i[0] & qm1_i;

  // Sign-extending M into the extra accumulator bit keeps -2^(WIDTH-1) exact.
  assign m_ext   = {m_i[WIDTH-1], m_i};
  assign operand = (m_ext ^ {(WIDTH+1){do_sub}}) & {(WIDTH+1){do_add | do_sub}};
  assign sum     = a_i + operand + {{WIDTH{1'b0}}, do_sub};

  assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier: valid/ready operand intake, WIDTH Booth steps,
// then the 2*WIDTH-bit signed product held until the consumer takes it.
//
// state | meaning
// IDLE  | ready for an operand pair; registers loaded on accept
// CALC  | one Booth step per clock, count down from WIDTH
// DONE  | product presented, held until out_ready
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = count_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   a_q, a_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic             qm1_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_step),
    .q_o   (q_step),
    .qm1_o (qm1_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = '0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered during reset.
        in_ready = ~reset;
        if (in_valid && in_ready) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_step;
        q_d   = q_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        product   = {a_q[WIDTH-1:0], q_q};
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: stimulus pushes reference products,
// an independent monitor pops and compares on every output handshake.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  logic           rdy_mode;
  logic           rdy_man;
  logic           rdy_rand;

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] sb[$];

  assign out_ready = rdy_mode ? rdy_rand : rdy_man;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed product must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", product);
      end else begin
        check("product", product, sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
    int  n;
    bit  done;
    @(posedge clk); #1;
    multiplicand = m;
    multiplier   = q;
    in_valid     = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(m, q));
        done = 1'b1;
      end
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 50);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [W-1:0] rm, rq;
    logic [W-1:0] picks[4];

    reset        = 1'b1;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    rdy_mode     = 1'b0;
    rdy_man      = 1'b0;

    #2;
    check("reset_in_ready", 16'(in_ready), 16'h0);
    check("reset_out_valid", 16'(out_valid), 16'h0);
    check("reset_product", product, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("idle_in_ready", 16'(in_ready), 16'h1);

    // Latency and backpressure on 3 * -4.
    issue(8'd3, 8'hFC);
    wait_out_valid(n);
    check("latency_cycles", 16'(n), 16'd8);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 16'(out_valid), 16'h1);
      check("bp_product", product, 16'hFFF4);
      check("bp_in_ready", 16'(in_ready), 16'h0);
      @(posedge clk); #1;
    end
    rdy_man = 1'b1;
    @(posedge clk); #1;
    rdy_man = 1'b0;
    check("post_consume_in_ready", 16'(in_ready), 16'h1);
    check("post_consume_out_valid", 16'(out_valid), 16'h0);
    check("post_consume_product", product, 16'h0);

    // New operands offered during CALC must be ignored.
    issue(8'h80, 8'h80);
    repeat (2) @(posedge clk);
    #1;
    multiplicand = 8'd5;
    multiplier   = 8'd5;
    in_valid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("calc_in_ready", 16'(in_ready), 16'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_man  = 1'b1;
    wait_drain();

    issue(8'd127, 8'h80);
    wait_drain();
    issue(8'd0, 8'hFF);
    wait_drain();
    issue(8'hFF, 8'hFF);
    wait_drain();

    // Randomized traffic with random consumer stalls.
    rdy_mode = 1'b1;
    picks[0] = 8'h80;
    picks[1] = 8'h7F;
    picks[2] = 8'h00;
    picks[3] = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      rm = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
      rq = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
      issue(rm, rq);
    end
    wait_drain();
    rdy_mode = 1'b0;
    rdy_man  = 1'b0;

    // Asynchronous reset while a product is being held.
    issue(8'd7, 8'd9);
    wait_out_valid(n);
    check("hold_product", product, 16'h003F);
    #2;
    reset = 1'b1;
    #1;
    check("rst_done_out_valid", 16'(out_valid), 16'h0);
    check("rst_done_product", product, 16'h0);
    check("rst_done_in_ready", 16'(in_ready), 16'h0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_done_release_in_ready", 16'(in_ready), 16'h1);

    // Asynchronous reset at step 4 of CALC, then a fresh 5 * 5.
    issue(8'd5, 8'd7);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_calc_out_valid", 16'(out_valid), 16'h0);
    check("rst_calc_product", product, 16'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_calc_release_in_ready", 16'(in_ready), 16'h1);
    issue(8'd5, 8'd5);
    wait_out_valid(n);
    check("fresh_latency", 16'(n), 16'd8);
    check("fresh_product_held", product, 16'h0019);
    rdy_man = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Sequential radix-2 Booth multiplier: the controller and datapath stage that consumes the conditional-invert (xorn) and gating primitives.
- Accepts one signed operand pair over a valid/ready handshake and iterates one Booth step per clock for WIDTH cycles.
- Returns the full-width signed product over a second valid/ready handshake.
- Sits between an operand source and any result consumer in the arithmetic path.

Parameters:
- WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- multiplicand  input  WIDTH  signed operand M.
- multiplier  input  WIDTH  signed operand Q.
- out_valid  output  1  product present.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  signed M*Q.

Behaviour:
- Reset values: in_ready=0 while reset is asserted, then 1 in IDLE; out_valid=0; product=0; state=IDLE; all internal registers 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load M, Q, A=0, q_m1=0, count=WIDTH, then go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle performs one Booth step and decrements count. When count reaches 1 at a step, go to DONE on that same edge.
  - DONE: out_valid=1; product = {A[WIDTH-1:0], Q}, held stable. On out_ready, go to IDLE. The earliest new accept is the following cycle.
- Booth step, examining {Q[0], q_m1}:
  - 01: A = A + M.
  - 10: A = A + ~M + 1, using xorn inversion with carry-in 1.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A, Q, q_m1} by one, replicating A's MSB.
- Accumulator A is WIDTH+1 bits, with M sign-extended to WIDTH+1. This makes M = -2^(WIDTH-1) correct with no overflow.
- Latency: accept edge E0, Booth steps on E1..EW, out_valid high from EW until out_ready is sampled high. Total WIDTH+1 cycles from accept to first possible consume, plus any consumer stall.
- Throughput: at most one operation in flight. in_valid during CALC or DONE is ignored; the operand is not captured.
- Backpressure: if out_ready=0 in DONE, product and out_valid are held indefinitely, unchanged.
- Reset mid-operation: the operation is aborted, no product is emitted, and the block returns to IDLE with reset values.
- Operands are sampled only on the accept edge. Changes afterwards have no effect.
- The count register is $clog2(WIDTH+1) bits and never wraps. The CALC→DONE transition is the only exit from CALC.

Decomposition:
- Package booth_pkg:
  - state_t enum {IDLE, CALC, DONE}.
  - Function for the count width.
- Shared macros remain in defs.svh.
- One sub-module, booth_step (combinational):
  - Inputs: A, Q, q_m1, M.
  - Outputs: next A, Q, q_m1.
  - Contents: the xorn-based add/subtract and the arithmetic shift.
- The top level holds the FSM, counter and registers only.

Test Plan:
- WIDTH=8, M=3, Q=-4 → product=16'hFFF4. out_valid rises exactly 8 cycles after the accept edge.
- M=-128, Q=-128 → product=16'h4000 (16384), checking the extended accumulator.
- M=127, Q=-128 → 16'hC080. M=0, Q=-1 → 16'h0000. M=-1, Q=-1 → 16'h0001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → product and out_valid stable. in_ready=0 throughout. Pulse out_ready → IDLE next cycle and in_ready=1.
- Assert in_valid with new operands during CALC → ignored; the result matches the first pair only.
- Assert reset at step 4 of CALC → out_valid=0 and product=0 immediately (asynchronous). After release, in_ready=1. A fresh 5*5 yields 16'h0019.
